pipa_moding_gen: RTL
====================

Name: pipa_moding_gen

Overview:
- Parametrised PIPA input spoofer for the FPGA AGC top levels.
- Replaces the fixed single-counter 3-3 moding stub with N independent axes. Each axis has a runtime-configurable plus/minus moding pattern.
- Counts on PIPASW and gates PIPDAT into per-axis PIPAp/PIPAm inputs of fpga_agc.
- Runs entirely in the SIM_CLK domain. PIPASW is treated as a level, not as a clock.

Parameters:
- N_AXES, 3, number of accelerometer axes (X, Y, Z order, bit 0 = X)
- CNT_W, 4, width of per-axis plus/minus counts (max 15 each)
- DEF_PLUS, 3, reset plus-phase length in PIPASW cycles
- DEF_MINUS, 3, reset minus-phase length in PIPASW cycles

Ports:
- SIM_CLK  in  1  simulation clock; all state on rising edge
- SIM_RST  in  1  asynchronous, active-high reset
- PIPASW  in  1  AGC PIPA switching strobe; a rising edge advances moding
- PIPDAT  in  1  AGC PIPA data-interrogate level
- enable  in  1  1 = generate pulses; 0 = freeze counters, outputs 0
- cfg_load  in  1  one-cycle request to update one axis pattern
- cfg_axis  in  $clog2(N_AXES)  target axis of cfg_load
- cfg_plus  in  CNT_W  new plus-phase length
- cfg_minus  in  CNT_W  new minus-phase length
- cfg_ack  out  1  one-cycle pulse: request accepted into the pending register
- PIPAp  out  N_AXES  plus pulse per axis
- PIPAm  out  N_AXES  minus pulse per axis
- wrap  out  N_AXES  one-cycle pulse when an axis completes a pattern period

Behaviour:
- Reset (async, active-high):
  - Per axis: cnt=0, plus_cur=DEF_PLUS, minus_cur=DEF_MINUS, no pending config.
  - PIPAp=0, PIPAm=0, wrap=0, cfg_ack=0; PIPASW edge register=0.
  - Reset mid-period discards any pending config.
- Edge detect:
  - sw_q <= PIPASW.
  - step = PIPASW & ~sw_q & enable.
  - A PIPASW held high counts once.
- Per-axis counter:
  - cnt is CNT_W+1 bits; total = plus_cur + minus_cur, also CNT_W+1 bits, no overflow.
  - On step with total != 0:
    - if cnt+1 >= total: cnt <= 0, wrap pulses, pending config (if valid) is copied to cur and cleared;
    - else cnt <= cnt+1.
  - On step with total == 0: cnt holds, any pending config is applied immediately, no wrap pulse.
- Phase: plus when cnt < plus_cur, else minus.
- Outputs, registered, one SIM_CLK latency from PIPDAT/cnt:
  - PIPAp[i] <= enable & PIPDAT & (total!=0) & plus_phase.
  - PIPAm[i] <= enable & PIPDAT & (total!=0) & ~plus_phase.
  - PIPAp[i] and PIPAm[i] are never both 1.
- Pattern edge cases:
  - plus=0 gives a minus-only pattern (constant negative delta-V).
  - minus=0 gives plus-only.
  - Both 0 idles the axis.
- Config:
  - cfg_load writes pending[cfg_axis] and sets pending_valid.
  - cfg_ack pulses the following cycle.
  - A second load before the wrap overwrites pending; the last value wins.
  - cfg_load in the same cycle as that axis's wrap: the old pending value is applied at the wrap, and the new request becomes pending for the next period.
  - cfg_axis >= N_AXES: request ignored, no cfg_ack.
- enable low:
  - counters and pending hold; outputs forced 0 next cycle.
  - Re-enable resumes at the held cnt.

Optional Feature:
- Macro PIPA_FAIL_INJ_EN.
- When defined:
  - Adds input fail_inj [N_AXES].
  - While fail_inj[i]=1 and PIPDAT=1, both PIPAp[i] and PIPAm[i] are driven 1, to exercise the AGC PIPA-fail alarm.
  - Counting is unaffected.
- When undefined:
  - The port is absent.
  - The mutual-exclusion property holds unconditionally.

Decomposition:
- Package pipa_moding_pkg:
  - CNT_W default and AXIS_X/Y/Z index constants.
  - typedef moding_cfg_t {plus, minus}.
  - Default pattern constant.
- Sub-module pipa_axis_moder, instantiated N_AXES times:
  - owns cnt, cur/pending config, wrap and output registers;
  - inputs: step, PIPDAT, enable, cfg_wr, cfg_data.
- Top does the edge detect, cfg decode and ack.

Test Plan:
- Reset, enable=1, PIPDAT=1 held, 12 PIPASW pulses -> each axis PIPAp high for pulses 1-3 and 7-9, PIPAm high for 4-6 and 10-12; wrap after pulses 6 and 12.
- cfg_load axis 1 to plus=2/minus=0 at cnt=4 -> cfg_ack next cycle; axis 1 finishes 3-3 period, then PIPAp only, wrap every 2 pulses; axes 0 and 2 unchanged.
- cfg plus=0/minus=0 on axis 2 -> PIPAp[2]=PIPAm[2]=0 for 10 pulses; reload 1/1 -> next pulse plus, following pulse minus.
- PIPASW held high 20 cycles -> one step only; enable=0 for 5 pulses -> no outputs, cnt unchanged after re-enable.
- Assert SIM_RST mid-period with pending config -> all outputs 0 immediately; after release, 3-3 default pattern restarts at cnt=0.
- PIPA_FAIL_INJ_EN: fail_inj[0]=1, PIPDAT=1 -> PIPAp[0]=PIPAm[0]=1 next cycle; without macro, assert PIPAp&PIPAm==0 for all cycles.

Source files
------------

// File: rtl/pipa_moding_pkg.sv
// Shared types and defaults for the PIPA moding generator.
// The optional PIPA_FAIL_INJ_EN build adds a per-axis fail-injection input.
package pipa_moding_pkg;

    localparam int CNT_W_DEF = 4;

    localparam int AXIS_X = 0;
    localparam int AXIS_Y = 1;
    localparam int AXIS_Z = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] plus;
        logic [CNT_W_DEF-1:0] minus;
    } moding_cfg_t;

    localparam moding_cfg_t DEF_CFG = '{plus: 4'd3, minus: 4'd3};

    // Index width that stays legal for a single-axis build.
    function automatic int axis_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipa_axis_moder.sv
// One accelerometer axis: plus/minus phase counter, pending pattern and output registers.
// With PIPA_FAIL_INJ_EN defined, fail_inj forces both pulse outputs while PIPDAT is high.
module pipa_axis_moder #(
    parameter int CNT_W     = 4,
    parameter int DEF_PLUS  = 3,
    parameter int DEF_MINUS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               pipdat,
    input  logic               enable,
    input  logic               cfg_wr,
    input  logic [2*CNT_W-1:0] cfg_data,
`ifdef PIPA_FAIL_INJ_EN
    input  logic               fail_inj,
`endif
    output logic               plus_pulse,
    output logic               minus_pulse,
    output logic               wrap
);

    logic [CNT_W:0]   cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   total;
    logic [CNT_W-1:0] plus_cur;
    logic [CNT_W-1:0] minus_cur;
    logic [CNT_W-1:0] plus_pend;
    logic [CNT_W-1:0] minus_pend;
    logic             pend_vld;
    logic             active;
    logic             plus_phase;
    logic             period_end;
    logic             force_both;

    assign total      = {1'b0, plus_cur} + {1'b0, minus_cur};
    assign cnt_inc    = cnt + {{CNT_W{1'b0}}, 1'b1};
    assign active     = (total != '0);
    assign plus_phase = (cnt < {1'b0, plus_cur});
    assign period_end = active && (cnt_inc >= total);

`ifdef PIPA_FAIL_INJ_EN
    assign force_both = fail_inj;
`else
    assign force_both = 1'b0;
`endif

    // A new request written in the same cycle as a wrap lands after the old pending is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            plus_cur   <= CNT_W'(DEF_PLUS);
            minus_cur  <= CNT_W'(DEF_MINUS);
            plus_pend  <= '0;
            minus_pend <= '0;
            pend_vld   <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (step) begin
                if (active) begin
                    if (period_end) begin
                        cnt  <= '0;
                        wrap <= 1'b1;
                        if (pend_vld) begin
                            plus_cur  <= plus_pend;
                            minus_cur <= minus_pend;
                            pend_vld  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else if (pend_vld) begin
                    plus_cur  <= plus_pend;
                    minus_cur <= minus_pend;
                    pend_vld  <= 1'b0;
                end
            end
            if (cfg_wr) begin
                plus_pend  <= cfg_data[2*CNT_W-1:CNT_W];
                minus_pend <= cfg_data[CNT_W-1:0];
                pend_vld   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plus_pulse  <= 1'b0;
            minus_pulse <= 1'b0;
        end else begin
            plus_pulse  <= enable & pipdat & ((active & plus_phase) | force_both);
            minus_pulse <= enable & pipdat & ((active & ~plus_phase) | force_both);
        end
    end

endmodule

// File: rtl/pipa_moding_gen.sv
// PIPA input spoofer: N independent axes with runtime plus/minus moding patterns.
// Optional build macro PIPA_FAIL_INJ_EN adds the fail_inj input.
module pipa_moding_gen
    import pipa_moding_pkg::*;
#(
    parameter int N_AXES    = 3,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEF_PLUS  = int'(DEF_CFG.plus),
    parameter int DEF_MINUS = int'(DEF_CFG.minus),
    localparam int AXIS_W   = axis_idx_w(N_AXES)
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              PIPASW,
    input  logic              PIPDAT,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic [AXIS_W-1:0] cfg_axis,
    input  logic [CNT_W-1:0]  cfg_plus,
    input  logic [CNT_W-1:0]  cfg_minus,
`ifdef PIPA_FAIL_INJ_EN
    input  logic [N_AXES-1:0] fail_inj,
`endif
    output logic              cfg_ack,
    output logic [N_AXES-1:0] PIPAp,
    output logic [N_AXES-1:0] PIPAm,
    output logic [N_AXES-1:0] wrap
);

    logic                sw_q;
    logic                step;
    logic                cfg_hit;
    logic [N_AXES-1:0]   cfg_wr;
    logic [2*CNT_W-1:0]  cfg_data;

    // PIPASW is sampled as a level; only its rising edge advances the pattern.
    assign step     = PIPASW & ~sw_q & enable;
    assign cfg_hit  = cfg_load && (32'(cfg_axis) < N_AXES);
    assign cfg_data = {cfg_plus, cfg_minus};

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            sw_q    <= 1'b0;
            cfg_ack <= 1'b0;
        end else begin
            sw_q    <= PIPASW;
            cfg_ack <= cfg_hit;
        end
    end

    for (genvar i = 0; i < N_AXES; i++) begin : g_axis
        assign cfg_wr[i] = cfg_hit && (cfg_axis == AXIS_W'(i));

        pipa_axis_moder #(
            .CNT_W     (CNT_W),
            .DEF_PLUS  (DEF_PLUS),
            .DEF_MINUS (DEF_MINUS)
        ) u_axis (
            .clk         (SIM_CLK),
            .rst         (SIM_RST),
            .step        (step),
            .pipdat      (PIPDAT),
            .enable      (enable),
            .cfg_wr      (cfg_wr[i]),
            .cfg_data    (cfg_data),
`ifdef PIPA_FAIL_INJ_EN
            .fail_inj    (fail_inj[i]),
`endif
            .plus_pulse  (PIPAp[i]),
            .minus_pulse (PIPAm[i]),
            .wrap        (wrap[i])
        );
    end

endmodule
